uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16: rx_tick pulses per bit period; the value is taken from the shared package.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rx_tick, input, 1 bit: one-clk pulse at 16x baud, driven by the baud generator RX_TICK.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-007 The block SHALL have port rx_data, output, DATA_BITS bits: last correctly framed byte.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data is updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-clk pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); all sampling SHALL use the synchronized value rx_s.
REQ-012 The state machine SHALL have states IDLE, START, DATA and STOP, with a 4-bit tick counter, a bit index and a DATA_BITS-wide shift register.
REQ-013 Counter, state and sampling SHALL advance only on clk cycles where rx_tick=1; with rx_tick=0 all state SHALL hold.
REQ-014 IDLE: on rx_tick with rx_s=0, the block SHALL go to START and clear the counter to 0.
REQ-015 START: on each tick the counter SHALL increment; at count 7 (mid start bit), rx_s=0 SHALL go to DATA with counter 0 and bit index 0, and rx_s=1 SHALL return to IDLE (glitch reject) with no output pulse.
REQ-016 DATA: at count OVERSAMPLE-1 the block SHALL shift rx_s in at the MSB end (LSB-first reception) and reset the counter to 0; after the DATA_BITS-th sample it SHALL go to STOP.
REQ-017 STOP: at count OVERSAMPLE-1, rx_s=1 SHALL load rx_data from the shift register and pulse rx_valid; rx_s=0 SHALL pulse frame_err and leave rx_data unchanged; both cases SHALL go to IDLE.
REQ-018 rx_valid and frame_err SHALL be registered, asserted in the clk cycle after the stop-sampling tick, high for exactly one clk, and never high together.
REQ-019 A continuous low line (break) SHALL yield repeated frames of 0x00, each ending in frame_err; no lockup is permitted.
REQ-020 Back-to-back frames SHALL be accepted: a start edge on the tick right after the STOP decision SHALL be detected from IDLE.
REQ-021 The counter SHALL wrap only through the explicit clears in REQ-015 to REQ-017; no arithmetic overflow is permitted.

Reset
REQ-022 Reset SHALL act asynchronously and set: state IDLE, counter 0, bit index 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid or frame_err pulse; after release the block SHALL wait in IDLE for a new start bit.

Structure
REQ-024 The shared package uart_pkg SHALL hold OVERSAMPLE=16, the START sample point 7, and the rx state enumeration (IDLE, START, DATA, STOP).
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter.
REQ-026 The rest of the block SHALL be one FSM plus datapath; expected RTL size is 150-250 lines.

Verification
REQ-027 The bench SHALL use the baud generator at 50 MHz / 9600 baud (RX_DIV=325) to drive rx_tick, with rx driven at 5208 clks per bit.
REQ-028 Frame 0x55 with a good stop bit -> exactly one rx_valid pulse, rx_data=0x55, frame_err never high.
REQ-029 Frames 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, rx_data=0x00 then 0xFF.
REQ-030 A low glitch of 3 ticks (975 clks) on idle rx -> busy returns low by tick 8 with no rx_valid or frame_err.
REQ-031 Frame 0xA5 with the stop bit driven low -> one frame_err pulse, no rx_valid, rx_data keeps its previous value.
REQ-032 Reset asserted during data bit 4 of 0x3C, then frame 0xC3 -> no pulse for 0x3C; rx_valid with rx_data=0xC3; rx_data=0 between reset and the 0xC3 frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package uart_pkg;

    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned START_SAMPLE = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1-style frames, LSB first, advanced only on rx_tick.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(START_SAMPLE);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    // Frame FSM and datapath; the counter only clears explicitly, never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == START_PT) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                idx   <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_END) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (idx == LAST_IDX) begin
                                state <= STOP;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_END) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (rx_s) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
